store_narrow_unit: RTL
======================

Name: store_narrow_unit

Overview:
Store-path counterpart of the load/immediate extension logic. It takes a 32-bit register value and truncates it to byte, halfword or word. It merges the result into a word-wide, word-addressed data memory using a read-modify-write sequence. It sits between the CPU datapath (sb/sh/sw) and the data RAM, and stalls the core through a busy/done handshake.

Parameters:
MEM_LAT, 1, read latency of the data RAM in cycles (legal 1..4); MemRData is valid MEM_LAT cycles after the MemRd cycle.
ADDR_W, 32, byte-address width; the word address is ADDR_W-2 bits.

Ports:
CLK  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
StoreReq  input  1  store request; sampled only when Busy=0.
StoreWidth  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
Addr  input  ADDR_W  byte address of the store.
RegData  input  32  register value to store; upper bits are discarded for narrow stores.
Busy  output  1  high whenever the FSM is not in IDLE.
Done  output  1  one-cycle pulse when the store has completed.
AlignErr  output  1  one-cycle pulse when a request is rejected.
MemAddr  output  ADDR_W-2  word address, equal to latched Addr[ADDR_W-1:2].
MemRd  output  1  one-cycle read strobe.
MemRData  input  32  read data from the RAM.
MemWr  output  1  one-cycle write strobe.
MemWData  output  32  merged write word.

Behaviour:
- Reset (Reset=0, asynchronous): state goes to IDLE. Busy, Done, AlignErr, MemRd and MemWr drop to 0 immediately. MemAddr, MemWData, the latched request and the wait counter clear to 0.
- Acceptance: in IDLE, when StoreReq=1, latch StoreWidth, Addr and RegData on the rising edge (cycle c0). Input changes after c0 are ignored. Requests are ignored while Busy=1; they are not queued.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- Error check at c0: the request is rejected if any of the following hold.
  - StoreWidth=11.
  - Halfword with Addr[0]=1.
  - Word with Addr[1:0]!=00.
  - Rejection path: IDLE->ERR. In c1, AlignErr=1 and Busy=1, with no MemRd or MemWr. Return to IDLE at c2. Done is not asserted.
- Word store: IDLE->WRITE->DONE->IDLE.
  - c1: MemWr=1, MemWData=RegData.
  - c2: Done=1.
  - c3: IDLE. No read is issued.
- Byte/halfword store: IDLE->READ->WAIT->WRITE->DONE->IDLE.
  - c1 (READ): MemRd=1 for exactly one cycle.
  - WAIT lasts MEM_LAT cycles, counted by a down-counter loaded with MEM_LAT at c1. MemRData is captured on the last WAIT edge, in cycle c1+MEM_LAT.
  - Cycle c2+MEM_LAT: WRITE with MemWr=1.
  - Next cycle: DONE (Done=1).
  - Latency from accept to Done is 3+MEM_LAT cycles.
- Merge (little-endian):
  - Byte at offset k=Addr[1:0]: MemWData = captured word with bits [8k+7:8k] replaced by RegData[7:0].
  - Halfword at h=Addr[1]: bits [16h+15:16h] replaced by RegData[15:0].
  - All other bytes pass through unchanged. RegData[31:8] or [31:16] never reach memory.
- MemAddr holds the latched word address from c1 until Done. It keeps that value in IDLE until the next accept.
- Busy=1 in READ, WAIT, WRITE, DONE and ERR. In the Done cycle Busy=1, so a new request is accepted no earlier than the cycle after Done.
- MemRd and MemWr are never high in the same cycle. Each is high for at most one cycle per request.
- Reset mid-operation: MemWr drops asynchronously. No partial write is reported and Done does not pulse. A write aborted in the WRITE cycle must be reissued by the CPU.
- MemWData is driven only in WRITE; it is 0 outside WRITE.

Test Plan:
- Word store: Addr=0x0000_0010, StoreWidth=10, RegData=0xDEAD_BEEF -> c1 MemWr=1, MemAddr=0x4, MemWData=0xDEADBEEF; c2 Done=1; MemRd never asserted.
- Byte store (MEM_LAT=1): Addr=0x13, RegData=0x1234_56AB, MemRData=0x1122_3344 -> MemRd at c1; MemWr at c3 with MemWData=0xAB22_3344; Done at c4.
- Halfword store: Addr=0x22, RegData=0xFFFF_CAFE, MemRData=0x0102_0304 -> MemWData=0xCAFE_0304, MemAddr=0x8.
- Rejections: halfword at Addr=0x21, word at Addr=0x22, and StoreWidth=11 -> each gives AlignErr=1 at c1 for one cycle, with MemRd=MemWr=Done=0 throughout.
- MEM_LAT=3: byte store -> MemRd at c1, capture at c4, MemWr at c5, Done at c6; StoreReq held high through the operation starts no second access until after Done.
- Reset: pull Reset low during WAIT of a byte store -> Busy, MemRd and MemWr go to 0 without a clock edge; no MemWr and no Done occur; after release a fresh word store completes normally.

Source files
------------

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//   Store-path narrowing and merge unit. Accepts an sb/sh/sw request from the
//   CPU, truncates RegData to the requested width and writes it into a
//   word-wide, word-addressed data RAM. Narrow stores use read-modify-write;
//   word stores write directly. The core is stalled via Busy until Done.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   StoreReq   in   store request, sampled only in IDLE
//   StoreWidth in   00 byte, 01 halfword, 10 word, 11 reserved
//   Addr       in   byte address of the store
//   RegData    in   register value to store
//   Busy       out  high whenever the FSM is not idle
//   Done       out  one-cycle completion pulse
//   AlignErr   out  one-cycle pulse for a rejected request
//   MemAddr    out  latched word address (Addr[ADDR_W-1:2])
//   MemRd      out  one-cycle RAM read strobe
//   MemRData   in   RAM read data, valid MEM_LAT cycles after MemRd
//   MemWr      out  one-cycle RAM write strobe
//   MemWData   out  merged write word, zero outside the write cycle

module store_narrow_unit #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              StoreReq,
  input  logic [1:0]        StoreWidth,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       RegData,
  output logic              Busy,
  output logic              Done,
  output logic              AlignErr,
  output logic [ADDR_W-3:0] MemAddr,
  output logic              MemRd,
  input  logic [31:0]       MemRData,
  output logic              MemWr,
  output logic [31:0]       MemWData
);

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone,
    StErr
  } stateT;

  stateT stateQ, stateD;

  logic [1:0]        widthQ;
  logic [1:0]        offsetQ;
  logic [ADDR_W-3:0] wordAddrQ;
  logic [31:0]       regDataQ;
  logic [31:0]       rdWordQ;
  logic [2:0]        waitCntQ, waitCntD;

  logic              accept;
  logic              reqErr;
  logic              lastWait;
  logic [31:0]       merged;

  assign accept   = (stateQ == StIdle) && StoreReq;
  assign lastWait = (stateQ == StWait) && (waitCntQ == 3'd1);

  // Reserved width, or a halfword/word that is not naturally aligned.
  always_comb begin
    reqErr = 1'b0;
    case (StoreWidth)
      2'b00:   reqErr = 1'b0;
      2'b01:   reqErr = Addr[0];
      2'b10:   reqErr = (Addr[1:0] != 2'b00);
      default: reqErr = 1'b1;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    case (stateQ)
      StIdle: begin
        if (StoreReq) begin
          if (reqErr) begin
            stateD = StErr;
          end else if (StoreWidth == 2'b10) begin
            stateD = StWrite;
          end else begin
            stateD = StRead;
          end
        end
      end
      StRead: begin
        stateD   = StWait;
        waitCntD = LatCnt;
      end
      StWait: begin
        if (waitCntQ == 3'd1) begin
          stateD = StWrite;
        end else begin
          waitCntD = waitCntQ - 3'd1;
        end
      end
      StWrite: stateD = StDone;
      StDone:  stateD = StIdle;
      StErr:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ    <= StIdle;
      waitCntQ  <= '0;
      widthQ    <= '0;
      offsetQ   <= '0;
      wordAddrQ <= '0;
      regDataQ  <= '0;
      rdWordQ   <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      if (accept) begin
        widthQ    <= StoreWidth;
        offsetQ   <= Addr[1:0];
        wordAddrQ <= Addr[ADDR_W-1:2];
        regDataQ  <= RegData;
      end
      // RAM data is only valid in the final wait cycle.
      if (lastWait) begin
        rdWordQ <= MemRData;
      end
    end
  end

  // Little-endian lane replacement; untouched lanes pass through.
  always_comb begin
    merged = rdWordQ;
    case (widthQ)
      2'b00:   merged[{offsetQ, 3'b000} +: 8]       = regDataQ[7:0];
      2'b01:   merged[{offsetQ[1], 4'b0000} +: 16]  = regDataQ[15:0];
      2'b10:   merged                               = regDataQ;
      default: merged                               = rdWordQ;
    endcase
  end

  assign Busy     = (stateQ != StIdle);
  assign Done     = (stateQ == StDone);
  assign AlignErr = (stateQ == StErr);
  assign MemRd    = (stateQ == StRead);
  assign MemWr    = (stateQ == StWrite);
  assign MemAddr  = wordAddrQ;
  assign MemWData = (stateQ == StWrite) ? merged : 32'h0;

endmodule
